// File: rtl/match_action_lookup.sv
// Three-stage ternary match-action lookup: compare, priority encode, action read.
// Lowest matching entry index wins; a miss or a bypassed key yields DEFAULT_ACTION.

module mal_entry #(
    parameter int KEY_LEN = 896
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               wr_en,
    input  logic [KEY_LEN-1:0] din,
    input  logic [KEY_LEN-1:0] din_mask,
    input  logic               din_vld,
    input  logic [KEY_LEN-1:0] key,
    output logic               hit
);
    logic [KEY_LEN-1:0] key_q;
    logic [KEY_LEN-1:0] mask_q;
    logic               vld_q;

    // Only the valid bit is reset; key/mask contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!aresetn)   vld_q <= 1'b0;
        else if (wr_en) vld_q <= din_vld;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_q  <= din;
            mask_q <= din_mask;
        end
    end

    assign hit = vld_q & (((key ^ key_q) & ~mask_q) == '0);
endmodule

module match_action_lookup #(
    parameter int                 KEY_LEN        = 896,
    parameter int                 DEPTH          = 16,
    parameter int                 ADDR_W         = $clog2(DEPTH),
    parameter int                 ACT_LEN        = 25,
    parameter int                 PHV_LEN        = 1579,
    parameter logic [ACT_LEN-1:0] DEFAULT_ACTION = 25'h3f,
    parameter int                 STAGE          = 0
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic [KEY_LEN-1:0] extract_key,
    input  logic               key_valid,
    input  logic               cond_flag,
    input  logic [PHV_LEN-1:0] pkt_hdr_vec,
    output logic [ACT_LEN-1:0] action,
    output logic               action_valid,
    output logic               action_hit,
    output logic [ADDR_W-1:0]  match_index,
    output logic [PHV_LEN-1:0] pkt_hdr_vec_out,
    input  logic [KEY_LEN-1:0] lookup_din,
    input  logic [KEY_LEN-1:0] lookup_din_mask,
    input  logic [ADDR_W-1:0]  lookup_din_addr,
    input  logic               lookup_din_vld,
    input  logic               lookup_din_en,
    input  logic [ACT_LEN-1:0] action_data_in,
    input  logic [ADDR_W-1:0]  action_addr,
    input  logic               action_en,
    input  logic               cnt_clr,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic               cond;
        logic [PHV_LEN-1:0] phv;
    } ctx_t;

    logic [DEPTH-1:0]   hit_vec;
    logic [DEPTH-1:0]   hit_s1;
    ctx_t               ctx_s1;
    ctx_t               ctx_s2;
    logic               hit_any_s2;
    logic [ADDR_W-1:0]  idx_s2;
    logic [ADDR_W-1:0]  enc_idx;
    logic               lookup_hit;
    logic [STAGES:1]    vld_pipe;
    logic [ACT_LEN-1:0] act_ram [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        mal_entry #(.KEY_LEN(KEY_LEN)) u_entry (
            .clk      (axis_clk),
            .aresetn  (aresetn),
            .wr_en    (lookup_din_en && (lookup_din_addr == ADDR_W'(i))),
            .din      (lookup_din),
            .din_mask (lookup_din_mask),
            .din_vld  (lookup_din_vld),
            .key      (extract_key),
            .hit      (hit_vec[i])
        );
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:1], key_valid};
    end

    // Payload registers carry no reset; vld_pipe alone qualifies them.
    always_ff @(posedge axis_clk) begin
        hit_s1      <= hit_vec;
        ctx_s1.cond <= cond_flag;
        ctx_s1.phv  <= pkt_hdr_vec;
        ctx_s2      <= ctx_s1;
        hit_any_s2  <= |hit_s1;
        idx_s2      <= enc_idx;
    end

    // Scan high to low so the lowest set index is the last assignment.
    always_comb begin
        enc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_s1[i]) enc_idx = ADDR_W'(i);
        end
    end

    assign lookup_hit = hit_any_s2 & ctx_s2.cond;

    always_ff @(posedge axis_clk) begin
        if (action_en) act_ram[action_addr] <= action_data_in;
    end

    // Stage-3 read sees the RAM contents before any same-edge write.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            action          <= '0;
            action_hit      <= 1'b0;
            match_index     <= '0;
            pkt_hdr_vec_out <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            action          <= lookup_hit ? act_ram[idx_s2] : DEFAULT_ACTION;
            action_hit      <= lookup_hit;
            match_index     <= lookup_hit ? idx_s2 : '0;
            pkt_hdr_vec_out <= ctx_s2.phv;
        end
    end

    assign action_valid = vld_pipe[STAGES];

    always_ff @(posedge axis_clk) begin
        if (!aresetn || cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            if (lookup_hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else if (ctx_s2.cond) begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
endmodule

// File: doc/match_action_lookup.md
Name: match_action_lookup

Overview:
- Parametrised, fully pipelined match-action lookup stage.
- Sits between the key extractor and the action engine in each pipeline stage.
- Holds a DEPTH-entry ternary match table (priority by lowest index) and a DEPTH-entry action RAM.
- Produces exactly one action result per accepted key, after a fixed latency, including a default action on miss.

Parameters:
- KEY_LEN, 896, width of lookup key and of each table entry.
- DEPTH, 16, number of table and action entries (power of 2, at least 2).
- ADDR_W, $clog2(DEPTH), entry index width.
- ACT_LEN, 25, action word width.
- PHV_LEN, 1579, packet header vector width carried alongside the key.
- DEFAULT_ACTION, 25'h3f, action emitted on miss or bypass.
- STAGE, 0, stage identifier (informational only, no logic effect).

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- extract_key  in  KEY_LEN  lookup key.
- key_valid  in  1  key/PHV valid, one-cycle qualifier.
- cond_flag  in  1  1 = perform lookup; 0 = bypass (forced default action).
- pkt_hdr_vec  in  PHV_LEN  PHV accompanying key.
- action  out  ACT_LEN  result action.
- action_valid  out  1  result qualifier, one-cycle pulse per accepted key.
- action_hit  out  1  1 = table hit; 0 = miss or bypass.
- match_index  out  ADDR_W  hit entry index; 0 when action_hit=0.
- pkt_hdr_vec_out  out  PHV_LEN  PHV aligned with action.
- lookup_din  in  KEY_LEN  entry key for table write.
- lookup_din_mask  in  KEY_LEN  entry mask; bit=1 means don't care.
- lookup_din_addr  in  ADDR_W  entry write index.
- lookup_din_vld  in  1  valid bit written with the entry (0 = invalidate).
- lookup_din_en  in  1  table write strobe.
- action_data_in  in  ACT_LEN  action RAM write data.
- action_addr  in  ADDR_W  action RAM write index.
- action_en  in  1  action RAM write strobe.
- cnt_clr  in  1  clear statistics counters.
- hit_cnt  out  32  saturating hit counter.
- miss_cnt  out  32  saturating miss counter.

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - All entry valid bits are cleared.
  - All pipeline valid bits are cleared.
  - action, action_valid, action_hit, match_index, pkt_hdr_vec_out, hit_cnt and miss_cnt are all 0.
  - Entry key/mask storage and the action RAM are not reset.
  - Reset asserted mid-operation discards all in-flight keys; no action_valid is produced for them.
- Pipeline:
  - No backpressure; one key is accepted every cycle that key_valid=1.
  - Key accepted at edge T produces action_valid=1 at edge T+3.
  - Stage 1 (compare): per entry, hit[i] = valid[i] & (((extract_key ^ key[i]) & ~mask[i]) == 0). Registers the hit vector, PHV and cond_flag.
  - Stage 2 (priority encode): the lowest set index wins. Registers hit_any and the winning index.
  - Stage 3 (action read): action = RAM[index] when hit_any & cond_flag; otherwise DEFAULT_ACTION.
- Output fields:
  - action_hit = hit_any & cond_flag.
  - match_index = winning index when action_hit=1, else 0.
  - PHV is delayed identically to the key.
  - When action_valid=0, action/action_hit/match_index/pkt_hdr_vec_out hold their last values.
- Table writes:
  - A write at edge W affects keys that enter stage 1 at edge W+1 or later.
  - A key that is in stage 1 at edge W compares against the old contents.
- Action RAM:
  - Write at edge W; a stage-3 read at the same edge returns the old data (read-first).
  - Writes are independent of table writes; both may occur in the same cycle.
- Counters:
  - On each action_valid, hit_cnt increments when action_hit=1.
  - miss_cnt increments when cond_flag=1 and there is no hit.
  - Bypass (cond_flag=0) increments neither counter.
  - Both counters saturate at 32'hFFFF_FFFF.
  - cnt_clr zeroes both counters and takes priority over a same-cycle increment.
- Mask all-ones on a valid entry matches every key.
- An invalid entry never matches, regardless of mask.

Test Plan:
- Reset, then key_valid=1 with key=0, cond_flag=1 -> 3 cycles later action_valid=1, action=25'h3f, action_hit=0, miss_cnt=1.
- Write entry 2 (key=K, mask=0, vld=1) and action[2]=25'h1234; send key K -> action=25'h1234, action_hit=1, match_index=2, PHV echoed unchanged, hit_cnt=1.
- Entries 3 and 5 both match K (entry 5 mask all-ones); send K -> match_index=3.
- Invalidate entry 3 and then send K -> match_index=5.
- Back-to-back keys K, X, K on consecutive cycles -> three consecutive action_valid pulses: hit, miss, hit, with PHVs in order.
- Send K with cond_flag=0 -> action=25'h3f, action_hit=0, both counters unchanged.
- Assert cnt_clr while a hit result is emerging -> hit_cnt=0.
- Assert aresetn=0 with two keys in flight -> no action_valid is produced for either.
